// File: rtl/apu_req_queue.sv
// Request FIFO and outstanding-response tracker between the core APU port and an APU accelerator.
// Define APU_REQ_QUEUE_BYPASS_EN to let requests skip the FIFO when it is empty (zero-cycle issue).
module apu_req_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned NARGS           = 3,
    parameter int unsigned WOP             = 6,
    parameter int unsigned NDSFLAGS        = 15,
    parameter int unsigned NUSFLAGS        = 5
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  core_req_i,
    output logic                                  core_gnt_o,
    input  logic [NARGS*32-1:0]                   core_operands_i,
    input  logic [WOP-1:0]                        core_op_i,
    input  logic [NDSFLAGS-1:0]                   core_flags_i,
    output logic                                  core_rvalid_o,
    output logic [31:0]                           core_result_o,
    output logic [NUSFLAGS-1:0]                   core_flags_o,
    output logic                                  acc_req_o,
    input  logic                                  acc_gnt_i,
    output logic [NARGS*32-1:0]                   acc_operands_o,
    output logic [WOP-1:0]                        acc_op_o,
    output logic [NDSFLAGS-1:0]                   acc_flags_o,
    input  logic                                  acc_rvalid_i,
    input  logic [31:0]                           acc_result_i,
    input  logic [NUSFLAGS-1:0]                   acc_flags_i,
    output logic [$clog2(DEPTH):0]                count_o,
    output logic [$clog2(MAX_OUTSTANDING):0]      outstanding_o,
    output logic                                  busy_o,
    output logic                                  err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [OW-1:0] OMAX = OW'(MAX_OUTSTANDING);

    logic [NARGS*32-1:0] opnd_mem [DEPTH];
    logic [WOP-1:0]      op_mem   [DEPTH];
    logic [NDSFLAGS-1:0] flag_mem [DEPTH];

    logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [OW-1:0]       out_q, out_d;
    logic                err_q, err_d;
    logic                rvalid_q;
    logic [31:0]         result_q;
    logic [NUSFLAGS-1:0] rflags_q;

    logic fifo_req, push, pop, issue, resp_ok;

    assign core_gnt_o = (count_q != FULL);
    assign fifo_req   = (count_q != '0) && (out_q < OMAX);
    assign pop        = fifo_req && acc_gnt_i;

`ifdef APU_REQ_QUEUE_BYPASS_EN
    logic bypass_avail, bypass_take;

    // An empty queue with issue credit forwards the core request directly.
    assign bypass_avail   = (count_q == '0) && (out_q < OMAX);
    assign bypass_take    = bypass_avail && core_req_i && acc_gnt_i;
    assign acc_req_o      = bypass_avail ? core_req_i      : fifo_req;
    assign acc_operands_o = bypass_avail ? core_operands_i : opnd_mem[rptr_q];
    assign acc_op_o       = bypass_avail ? core_op_i       : op_mem[rptr_q];
    assign acc_flags_o    = bypass_avail ? core_flags_i    : flag_mem[rptr_q];
    assign push           = core_req_i && core_gnt_o && !bypass_take;
    assign issue          = pop || bypass_take;
`else
    assign acc_req_o      = fifo_req;
    assign acc_operands_o = opnd_mem[rptr_q];
    assign acc_op_o       = op_mem[rptr_q];
    assign acc_flags_o    = flag_mem[rptr_q];
    assign push           = core_req_i && core_gnt_o;
    assign issue          = pop;
`endif

    // A response is only legitimate if something is in flight, counting a same-cycle issue.
    assign resp_ok = acc_rvalid_i && ((out_q != '0) || issue);

    always_comb begin
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        out_d = out_q;
        if (issue && !resp_ok) begin
            out_d = out_q + OW'(1);
        end else if (resp_ok && !issue) begin
            out_d = out_q - OW'(1);
        end
        err_d = err_q || (acc_rvalid_i && !resp_ok);
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            opnd_mem[wptr_q] <= core_operands_i;
            op_mem[wptr_q]   <= core_op_i;
            flag_mem[wptr_q] <= core_flags_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            out_q    <= '0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            result_q <= '0;
            rflags_q <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
            err_q    <= err_d;
            rvalid_q <= resp_ok;
            if (resp_ok) begin
                result_q <= acc_result_i;
                rflags_q <= acc_flags_i;
            end
        end
    end

    assign core_rvalid_o = rvalid_q;
    assign core_result_o = result_q;
    assign core_flags_o  = rflags_q;
    assign count_o       = count_q;
    assign outstanding_o = out_q;
    assign busy_o        = (count_q != '0) || (out_q != '0);
    assign err_o         = err_q;

endmodule

// File: tb/tb_apu_req_queue.sv
// Self-checking bench for apu_req_queue: directed scenarios plus a randomized run against a queue model.
module tb_apu_req_queue;
    localparam int DEPTH = 4;
    localparam int MAXO  = 4;

    typedef struct packed {
        logic [95:0] ops;
        logic [5:0]  op;
        logic [14:0] flags;
    } req_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        core_req_i = 1'b0;
    logic        core_gnt_o;
    logic [95:0] core_operands_i = '0;
    logic [5:0]  core_op_i = '0;
    logic [14:0] core_flags_i = '0;
    logic        core_rvalid_o;
    logic [31:0] core_result_o;
    logic [4:0]  core_flags_o;
    logic        acc_req_o;
    logic        acc_gnt_i = 1'b0;
    logic [95:0] acc_operands_o;
    logic [5:0]  acc_op_o;
    logic [14:0] acc_flags_o;
    logic        acc_rvalid_i = 1'b0;
    logic [31:0] acc_result_i = '0;
    logic [4:0]  acc_flags_i = '0;
    logic [2:0]  count_o;
    logic [2:0]  outstanding_o;
    logic        busy_o;
    logic        err_o;

    int nCmp = 0;
    int nFail = 0;

    apu_req_queue dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_req_i(core_req_i), .core_gnt_o(core_gnt_o),
        .core_operands_i(core_operands_i), .core_op_i(core_op_i), .core_flags_i(core_flags_i),
        .core_rvalid_o(core_rvalid_o), .core_result_o(core_result_o), .core_flags_o(core_flags_o),
        .acc_req_o(acc_req_o), .acc_gnt_i(acc_gnt_i),
        .acc_operands_o(acc_operands_o), .acc_op_o(acc_op_o), .acc_flags_o(acc_flags_o),
        .acc_rvalid_i(acc_rvalid_i), .acc_result_i(acc_result_i), .acc_flags_i(acc_flags_i),
        .count_o(count_o), .outstanding_o(outstanding_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clearInputs();
        core_req_i      = 1'b0;
        core_operands_i = '0;
        core_op_i       = '0;
        core_flags_i    = '0;
        acc_gnt_i       = 1'b0;
        acc_rvalid_i    = 1'b0;
        acc_result_i    = '0;
        acc_flags_i     = '0;
    endtask

    task automatic do_reset();
        clearInputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        nCmp++;
        if ({count_o, outstanding_o, busy_o, err_o} !== 8'b0) begin
            nFail++;
            $display("[TB] FAIL reset_state got cnt=%0d out=%0d busy=%b err=%b want all 0", count_o, outstanding_o, busy_o, err_o);
        end
        nCmp++;
        if ({core_gnt_o, acc_req_o, core_rvalid_o} !== 3'b100) begin
            nFail++;
            $display("[TB] FAIL reset_hs got gnt=%b req=%b rvalid=%b want 1 0 0", core_gnt_o, acc_req_o, core_rvalid_o);
        end
        nCmp++;
        if ({core_result_o, core_flags_o} !== 37'b0) begin
            nFail++;
            $display("[TB] FAIL reset_result got %h/%h want 0/0", core_result_o, core_flags_o);
        end
    endtask

    task automatic test_single_op();
        bit expReq0;
        do_reset();
        core_req_i = 1'b1;
        core_op_i = 6'h05;
        core_operands_i = {64'h0, 32'h1234};
        acc_gnt_i = 1'b1;
`ifdef APU_REQ_QUEUE_BYPASS_EN
        expReq0 = 1'b1;
`else
        expReq0 = 1'b0;
`endif
        #1;
        nCmp++;
        if (core_gnt_o !== 1'b1 || acc_req_o !== expReq0) begin
            nFail++;
            $display("[TB] FAIL single_cycle0 got gnt=%b req=%b want 1 %b", core_gnt_o, acc_req_o, expReq0);
        end
        tick();
        core_req_i = 1'b0;
        if (!expReq0) begin
            #1;
            nCmp++;
            if (acc_req_o !== 1'b1 || acc_op_o !== 6'h05 || acc_operands_o[31:0] !== 32'h1234 || count_o !== 3'd1) begin
                nFail++;
                $display("[TB] FAIL single_issue got req=%b op=%h opnd=%h cnt=%0d want 1 05 1234 1", acc_req_o, acc_op_o, acc_operands_o[31:0], count_o);
            end
            tick();
        end
        nCmp++;
        if (outstanding_o !== 3'd1 || count_o !== 3'd0) begin
            nFail++;
            $display("[TB] FAIL single_outst got out=%0d cnt=%0d want 1 0", outstanding_o, count_o);
        end
        tick();
        acc_rvalid_i = 1'b1;
        acc_result_i = 32'hCAFE;
        acc_flags_i = 5'h3;
        #1;
        nCmp++;
        if (core_rvalid_o !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL single_early_rvalid got %b want 0", core_rvalid_o);
        end
        tick();
        acc_rvalid_i = 1'b0;
        acc_result_i = 32'hDEAD;
        nCmp++;
        if (core_rvalid_o !== 1'b1 || core_result_o !== 32'hCAFE || core_flags_o !== 5'h3 || outstanding_o !== 3'd0 || busy_o !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL single_resp got rv=%b res=%h fl=%h out=%0d busy=%b want 1 cafe 3 0 0", core_rvalid_o, core_result_o, core_flags_o, outstanding_o, busy_o);
        end
        tick();
        nCmp++;
        if (core_rvalid_o !== 1'b0 || core_result_o !== 32'hCAFE) begin
            nFail++;
            $display("[TB] FAIL single_hold got rv=%b res=%h want 0 cafe", core_rvalid_o, core_result_o);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            core_req_i = 1'b1;
            core_op_i = 6'(i + 1);
            #1;
            nCmp++;
            if (core_gnt_o !== (i < DEPTH)) begin
                nFail++;
                $display("[TB] FAIL fill_gnt%0d got %b want %b", i, core_gnt_o, (i < DEPTH));
            end
            tick();
        end
        core_req_i = 1'b0;
        acc_gnt_i = 1'b1;
        #1;
        nCmp++;
        if (count_o !== 3'd4 || acc_req_o !== 1'b1 || acc_op_o !== 6'd1) begin
            nFail++;
            $display("[TB] FAIL fill_full got cnt=%0d req=%b op=%0d want 4 1 1", count_o, acc_req_o, acc_op_o);
        end
        tick();
        acc_gnt_i = 1'b0;
        #1;
        nCmp++;
        if (core_gnt_o !== 1'b1 || count_o !== 3'd3 || acc_op_o !== 6'd2) begin
            nFail++;
            $display("[TB] FAIL fill_drain got gnt=%b cnt=%0d op=%0d want 1 3 2", core_gnt_o, count_o, acc_op_o);
        end
    endtask

    task automatic test_outstanding_limit();
        do_reset();
        acc_gnt_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            core_req_i = 1'b1;
            core_op_i = 6'(i + 10);
            tick();
        end
        core_req_i = 1'b0;
        #1;
        nCmp++;
        if (outstanding_o !== 3'd4 || count_o !== 3'd2 || acc_req_o !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL limit_stall got out=%0d cnt=%0d req=%b want 4 2 0", outstanding_o, count_o, acc_req_o);
        end
        acc_rvalid_i = 1'b1;
        acc_result_i = 32'h77;
        tick();
        acc_rvalid_i = 1'b0;
        nCmp++;
        if (outstanding_o !== 3'd3 || acc_req_o !== 1'b1 || acc_op_o !== 6'd14) begin
            nFail++;
            $display("[TB] FAIL limit_resume got out=%0d req=%b op=%0d want 3 1 14", outstanding_o, acc_req_o, acc_op_o);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        core_req_i = 1'b1;
        repeat (2) tick();
        nCmp++;
        if (count_o !== 3'd2) begin
            nFail++;
            $display("[TB] FAIL simul_setup got cnt=%0d want 2", count_o);
        end
        acc_gnt_i = 1'b1;
        repeat (3) tick();
        nCmp++;
        if (count_o !== 3'd2 || outstanding_o !== 3'd3) begin
            nFail++;
            $display("[TB] FAIL simul_pushpop got cnt=%0d out=%0d want 2 3", count_o, outstanding_o);
        end
        acc_rvalid_i = 1'b1;
        acc_result_i = 32'h55;
        tick();
        acc_rvalid_i = 1'b0;
        acc_gnt_i = 1'b0;
        core_req_i = 1'b0;
        nCmp++;
        if (count_o !== 3'd2 || outstanding_o !== 3'd3 || core_rvalid_o !== 1'b1 || core_result_o !== 32'h55) begin
            nFail++;
            $display("[TB] FAIL simul_poprsp got cnt=%0d out=%0d rv=%b res=%h want 2 3 1 55", count_o, outstanding_o, core_rvalid_o, core_result_o);
        end
    endtask

    task automatic test_error_reset();
        do_reset();
        acc_rvalid_i = 1'b1;
        acc_result_i = 32'hBAD;
        tick();
        acc_rvalid_i = 1'b0;
        nCmp++;
        if (core_rvalid_o !== 1'b0 || err_o !== 1'b1 || core_result_o !== 32'h0) begin
            nFail++;
            $display("[TB] FAIL err_set got rv=%b err=%b res=%h want 0 1 0", core_rvalid_o, err_o, core_result_o);
        end
        core_req_i = 1'b1;
        repeat (3) tick();
        core_req_i = 1'b0;
        nCmp++;
        if (count_o !== 3'd3 || err_o !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL err_sticky got cnt=%0d err=%b want 3 1", count_o, err_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        nCmp++;
        if (count_o !== 3'd0 || outstanding_o !== 3'd0 || err_o !== 1'b0 || acc_req_o !== 1'b0 || busy_o !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL async_reset got cnt=%0d out=%0d err=%b req=%b busy=%b want 0 0 0 0 0", count_o, outstanding_o, err_o, acc_req_o, busy_o);
        end
        tick();
        rst_ni = 1'b1;
        acc_rvalid_i = 1'b1;
        tick();
        acc_rvalid_i = 1'b0;
        nCmp++;
        if (err_o !== 1'b1 || core_rvalid_o !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL late_rvalid got err=%b rv=%b want 1 0", err_o, core_rvalid_o);
        end
    endtask

`ifdef APU_REQ_QUEUE_BYPASS_EN
    task automatic test_bypass();
        do_reset();
        core_req_i = 1'b1;
        core_op_i = 6'h2A;
        acc_gnt_i = 1'b1;
        #1;
        nCmp++;
        if (acc_req_o !== 1'b1 || acc_op_o !== 6'h2A || core_gnt_o !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL bypass_comb got req=%b op=%h gnt=%b want 1 2a 1", acc_req_o, acc_op_o, core_gnt_o);
        end
        tick();
        clearInputs();
        nCmp++;
        if (count_o !== 3'd0 || outstanding_o !== 3'd1) begin
            nFail++;
            $display("[TB] FAIL bypass_count got cnt=%0d out=%0d want 0 1", count_o, outstanding_o);
        end
    endtask
`endif

    // Randomized traffic against a queue-and-counter model of the block.
    task automatic test_random();
        req_t        q[$];
        req_t        cur;
        int          outM;
        bit          errM, rvM, byp, take, pushM, popM, issueM, respM, expReq;
        logic [31:0] resM;
        logic [4:0]  flgM;
        do_reset();
        outM = 0; errM = 0; rvM = 0; resM = '0; flgM = '0;
        for (int i = 0; i < 800; i++) begin
            cur.ops   = {$urandom, $urandom, $urandom};
            cur.op    = 6'($urandom);
            cur.flags = 15'($urandom);
            core_req_i      = ($urandom_range(0, 2) != 0);
            core_operands_i = cur.ops;
            core_op_i       = cur.op;
            core_flags_i    = cur.flags;
            acc_gnt_i       = ($urandom_range(0, 2) == 0);
            acc_rvalid_i    = (outM > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
            acc_result_i    = $urandom;
            acc_flags_i     = 5'($urandom);
            #1;
            byp = 1'b0;
`ifdef APU_REQ_QUEUE_BYPASS_EN
            byp = (q.size() == 0) && (outM < MAXO);
`endif
            expReq = byp ? core_req_i : ((q.size() > 0) && (outM < MAXO));
            nCmp++;
            if (core_gnt_o !== (q.size() < DEPTH) || acc_req_o !== expReq) begin
                nFail++;
                $display("[TB] FAIL rnd_hs[%0d] got gnt=%b req=%b want %b %b", i, core_gnt_o, acc_req_o, (q.size() < DEPTH), expReq);
            end
            if (!byp && q.size() > 0) begin
                nCmp++;
                if ({acc_operands_o, acc_op_o, acc_flags_o} !== q[0]) begin
                    nFail++;
                    $display("[TB] FAIL rnd_head[%0d] got op=%h want %h", i, acc_op_o, q[0].op);
                end
            end
            take   = byp && core_req_i && acc_gnt_i;
            popM   = !byp && (q.size() > 0) && (outM < MAXO) && acc_gnt_i;
            pushM  = core_req_i && (q.size() < DEPTH) && !take;
            issueM = popM || take;
            respM  = acc_rvalid_i && (outM > 0 || issueM);
            if (acc_rvalid_i && !respM) errM = 1'b1;
            if (popM) void'(q.pop_front());
            if (pushM) q.push_back(cur);
            outM = outM + int'(issueM) - int'(respM);
            rvM = respM;
            if (respM) begin
                resM = acc_result_i;
                flgM = acc_flags_i;
            end
            tick();
            nCmp++;
            if (count_o !== 3'(q.size()) || outstanding_o !== 3'(outM) || busy_o !== (q.size() != 0 || outM != 0) || err_o !== errM) begin
                nFail++;
                $display("[TB] FAIL rnd_state[%0d] got cnt=%0d out=%0d busy=%b err=%b want %0d %0d %b %b", i, count_o, outstanding_o, busy_o, err_o, q.size(), outM, (q.size() != 0 || outM != 0), errM);
            end
            nCmp++;
            if (core_rvalid_o !== rvM || core_result_o !== resM || core_flags_o !== flgM) begin
                nFail++;
                $display("[TB] FAIL rnd_resp[%0d] got rv=%b res=%h fl=%h want %b %h %h", i, core_rvalid_o, core_result_o, core_flags_o, rvM, resM, flgM);
            end
        end
        clearInputs();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_fill();
        test_outstanding_limit();
        test_simultaneous();
        test_error_reset();
`ifdef APU_REQ_QUEUE_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/apu_req_queue.md
Name: apu_req_queue

Overview:
- Buffers APU requests between the core's APU master port and an APU-protocol accelerator slave.
- Decouples the core-side grant from accelerator back-pressure using a request FIFO.
- Tracks issued-but-unanswered operations with an outstanding counter and returns results to the core in order, registered.
- Sits between the core APU interface and the vector accelerator or APU dummy responder.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, at least 2.
- MAX_OUTSTANDING, 4, maximum requests issued to the accelerator without a response.
- NARGS, 3, operand count (cv32e40p_apu_core_pkg APU_NARGS_CPU).
- WOP, 6, opcode width (APU_WOP_CPU).
- NDSFLAGS, 15, downstream flag width (APU_NDSFLAGS_CPU).
- NUSFLAGS, 5, upstream flag width (APU_NUSFLAGS_CPU).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- core_req_i  in  1  core request valid
- core_gnt_o  out  1  request accepted this cycle
- core_operands_i  in  NARGS*32  operands
- core_op_i  in  WOP  opcode
- core_flags_i  in  NDSFLAGS  downstream flags
- core_rvalid_o  out  1  result valid, one-cycle pulse
- core_result_o  out  32  result
- core_flags_o  out  NUSFLAGS  upstream flags
- acc_req_o  out  1  request to accelerator
- acc_gnt_i  in  1  accelerator grant
- acc_operands_o  out  NARGS*32  head-entry operands
- acc_op_o  out  WOP  head-entry opcode
- acc_flags_o  out  NDSFLAGS  head-entry flags
- acc_rvalid_i  in  1  accelerator result valid
- acc_result_i  in  32  accelerator result
- acc_flags_i  in  NUSFLAGS  accelerator flags
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  issued, unanswered
- busy_o  out  1  count_o != 0 or outstanding_o != 0
- err_o  out  1  sticky: response seen with nothing outstanding

Behaviour:
- Reset:
  - FIFO pointers, count, outstanding and err_o cleared.
  - core_rvalid_o = 0; core_result_o and core_flags_o = 0.
  - core_gnt_o = 1 (FIFO empty); acc_req_o = 0; busy_o = 0.
  - Reset mid-operation discards all queued and outstanding requests; late acc_rvalid_i after reset sets err_o.
- Push:
  - core_gnt_o = (count != DEPTH), combinational; must not depend on core_req_i.
  - Enqueue occurs on core_req_i && core_gnt_o.
  - When full, grant stays low even if a pop happens the same cycle; no push-through-full.
- Issue:
  - acc_req_o = (count != 0) && (outstanding < MAX_OUTSTANDING).
  - acc_operands_o, acc_op_o and acc_flags_o present the head entry whenever count != 0 and hold stable until granted.
  - Pop on acc_req_o && acc_gnt_i.
  - Latency: a request accepted in cycle N appears on acc_req_o no earlier than cycle N+1.
- Counters:
  - count: +1 push, -1 pop, unchanged on simultaneous push and pop.
  - Pointers wrap modulo DEPTH.
  - outstanding: +1 on pop, -1 on acc_rvalid_i, unchanged on both in the same cycle.
  - outstanding never exceeds MAX_OUTSTANDING.
- Response:
  - core_rvalid_o, core_result_o and core_flags_o are registered from acc_rvalid_i, acc_result_i and acc_flags_i: one cycle latency.
  - core_result_o and core_flags_o hold their last value when core_rvalid_o = 0.
  - acc_rvalid_i with outstanding == 0 and no same-cycle pop: response dropped (no core_rvalid_o), err_o set until reset.
- Responses are assumed in order from the accelerator; no reordering or tagging.

Optional Feature:
- Macro: APU_REQ_QUEUE_BYPASS_EN.
- Defined:
  - When count == 0 and outstanding < MAX_OUTSTANDING, core_req_i drives acc_req_o combinationally and core fields pass straight to acc_* outputs.
  - If acc_gnt_i is high that cycle: the request is not enqueued, outstanding increments, and core_gnt_o = 1.
  - Otherwise the request is enqueued normally.
  - Zero-cycle issue latency.
- Undefined: always at least 1-cycle issue latency, with no combinational path from core_* to acc_*.

Test Plan:
- Single op:
  - Stimulus: core_req_i for 1 cycle, op = 6'h05, operand0 = 32'h1234, acc_gnt_i tied 1, accelerator answers 2 cycles after grant with result 32'hCAFE.
  - Response: acc_req_o in cycle 1, outstanding_o = 1, core_rvalid_o one cycle after acc_rvalid_i with core_result_o = 32'hCAFE, then busy_o = 0.
- Fill:
  - Stimulus: acc_gnt_i = 0, 5 back-to-back requests, DEPTH = 4.
  - Response: the first 4 are granted, core_gnt_o = 0 on the 5th, count_o = 4; after acc_gnt_i is raised for 1 cycle, core_gnt_o returns to 1.
- Outstanding limit:
  - Stimulus: acc_gnt_i = 1, no responses, 6 requests.
  - Response: acc_req_o drops once outstanding_o = 4 and count_o = 2; one acc_rvalid_i re-enables issue on the next cycle.
- Simultaneous events:
  - Stimulus: push with pop in one cycle at count = 2, and pop with acc_rvalid_i in one cycle at outstanding = 3.
  - Response: count_o stays 2 and outstanding_o stays 3.
- Error and reset:
  - Stimulus: acc_rvalid_i with outstanding = 0.
  - Response: no core_rvalid_o and err_o = 1.
  - Stimulus: assert rst_ni low with count = 3.
  - Response: all counters 0, err_o = 0, acc_req_o = 0 immediately (asynchronous).
- Bypass (APU_REQ_QUEUE_BYPASS_EN):
  - Stimulus: empty queue, core_req_i with acc_gnt_i = 1.
  - Response: acc_req_o in the same cycle, count_o stays 0, outstanding_o = 1.
